register_access_stage_ctrl: RTL and testbench

Pipeline control for the register-access stage, between decode and address generation. Holds one decoded instruction and presents its operand codes to the segment-register stall table. Issues the instruction only when the table reports no hazard and the outbound buffer has room. Issued instructions go into a 2-entry output buffer with a valid/ready interface to the next stage.

---
 rtl/register_access_stage_ctrl_pkg.sv | 23 ++
 rtl/register_access_stage_ctrl_rac_skid_fifo.sv | 49 ++++
 rtl/register_access_stage_ctrl.sv | 99 +++++++++
 tb/tb_register_access_stage_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_access_stage_ctrl_pkg.sv
// Shared constants and types for the register-access stage control block.
package register_access_stage_ctrl_pkg;
    localparam int OP_W           = 3;
    localparam int OPS_W          = 4 * OP_W;
    localparam int RAC_FIFO_DEPTH = 2;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_TYPE_SEG  = 3'b010;
    localparam op_t OP_TYPE_NONE = 3'b000;

    typedef struct packed {
        op_t op0;
        op_t op0_reg;
        op_t op1;
        op_t op1_reg;
    } rac_ops_t;

    // Operand types leaving an empty slot must never look like a segment op.
    function automatic op_t mask_op(input logic vld, input op_t op);
        return vld ? op : OP_TYPE_NONE;
    endfunction
endpackage

// File: rtl/register_access_stage_ctrl_rac_skid_fifo.sv
// Two-entry output FIFO for issued instructions; full is a registered-count decode.
module rac_skid_fifo
    import register_access_stage_ctrl_pkg::*;
#(
    parameter int WIDTH = 76
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);
    logic [RAC_FIFO_DEPTH-1:0][WIDTH-1:0] mem;
    logic                                 wr_ptr;
    logic                                 rd_ptr;
    logic [1:0]                           count;
    logic                                 pop;

    assign out_valid = (count != 2'd0);
    assign full      = (count == 2'(RAC_FIFO_DEPTH));
    assign pop       = out_valid & pop_ready;
    assign out_data  = mem[rd_ptr];

    // One-bit pointers give the modulo-2 wrap for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/register_access_stage_ctrl.sv
// Register-access stage control: hold register, stall-table handshake, 2-entry output FIFO.
// Optional stall performance counter built when REG_ACCESS_STALL_PERF_EN is defined.
module register_access_stage_ctrl
    import register_access_stage_ctrl_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  logic [OP_W-1:0]          in_op0,
    input  logic [OP_W-1:0]          in_op0_reg,
    input  logic [OP_W-1:0]          in_op1,
    input  logic [OP_W-1:0]          in_op1_reg,
    output logic [OP_W-1:0]          st_op0,
    output logic [OP_W-1:0]          st_op0_reg,
    output logic [OP_W-1:0]          st_op1,
    output logic [OP_W-1:0]          st_op1_reg,
    output logic                     st_next_stage_ready,
    input  logic                     seg_stall,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [OP_W-1:0]          out_op0,
    output logic [OP_W-1:0]          out_op0_reg,
    output logic [OP_W-1:0]          out_op1,
    output logic [OP_W-1:0]          out_op1_reg,
    output logic [31:0]              stall_cycles
);
    localparam int ENTRY_W = PAYLOAD_WIDTH + OPS_W;

    logic                     h_valid;
    logic [PAYLOAD_WIDTH-1:0] h_payload;
    rac_ops_t                 h_ops;
    logic                     fifo_full;
    logic                     issue;
    logic                     load;
    logic [ENTRY_W-1:0]       fifo_out;
    rac_ops_t                 out_ops;

    // Space is judged on the registered count only, keeping out_ready off the issue path.
    assign issue    = h_valid & ~seg_stall & ~fifo_full & ~flush;
    assign in_ready = ~flush & (~h_valid | issue);
    assign load     = in_valid & in_ready;

    assign st_op0              = mask_op(h_valid, h_ops.op0);
    assign st_op1              = mask_op(h_valid, h_ops.op1);
    assign st_op0_reg          = h_ops.op0_reg;
    assign st_op1_reg          = h_ops.op1_reg;
    assign st_next_stage_ready = issue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_valid   <= 1'b0;
            h_payload <= '0;
            h_ops     <= '0;
        end else if (flush) begin
            h_valid <= 1'b0;
        end else if (load) begin
            h_valid   <= 1'b1;
            h_payload <= in_payload;
            h_ops     <= '{op0: in_op0, op0_reg: in_op0_reg, op1: in_op1, op1_reg: in_op1_reg};
        end else if (issue) begin
            h_valid <= 1'b0;
        end
    end

    rac_skid_fifo #(.WIDTH(ENTRY_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (issue),
        .push_data ({h_ops, h_payload}),
        .pop_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (fifo_out),
        .full      (fifo_full)
    );

    assign {out_ops, out_payload} = fifo_out;
    assign out_op0     = out_ops.op0;
    assign out_op0_reg = out_ops.op0_reg;
    assign out_op1     = out_ops.op1;
    assign out_op1_reg = out_ops.op1_reg;

`ifdef REG_ACCESS_STALL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (h_valid & seg_stall & ~flush & ~(&stall_cycles))
            stall_cycles <= stall_cycles + 32'd1;
    end
`else
    assign stall_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_register_access_stage_ctrl.sv
// Scoreboard bench for register_access_stage_ctrl: transaction-level model of hold slot and output queue.
module tb_register_access_stage_ctrl;
    localparam int PW = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_payload = '0;
    logic [2:0]    in_op0 = '0, in_op0_reg = '0, in_op1 = '0, in_op1_reg = '0;
    logic [2:0]    st_op0, st_op0_reg, st_op1, st_op1_reg;
    logic          st_next_stage_ready;
    logic          seg_stall = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_payload;
    logic [2:0]    out_op0, out_op0_reg, out_op1, out_op1_reg;
    logic [31:0]   stall_cycles;

    register_access_stage_ctrl #(.PAYLOAD_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_op0(in_op0), .in_op0_reg(in_op0_reg), .in_op1(in_op1), .in_op1_reg(in_op1_reg),
        .st_op0(st_op0), .st_op0_reg(st_op0_reg), .st_op1(st_op1), .st_op1_reg(st_op1_reg),
        .st_next_stage_ready(st_next_stage_ready), .seg_stall(seg_stall),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_op0(out_op0), .out_op0_reg(out_op0_reg), .out_op1(out_op1), .out_op1_reg(out_op1_reg),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] p;
        logic [2:0]    o0, r0, o1, r1;
    } item_t;

    item_t           sb[$];
    item_t           mh;
    bit              mh_valid = 1'b0;
    int              sb_pre = 0;
    bit              last_acc = 1'b0;
    longint unsigned exp_stall = 0;
    int              checks = 0;
    int              fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic item_t rnd_item();
        item_t it;
        it.p  = {$urandom, $urandom};
        it.o0 = 3'($urandom_range(0, 7));
        it.r0 = 3'($urandom_range(0, 7));
        it.o1 = 3'($urandom_range(0, 7));
        it.r1 = 3'($urandom_range(0, 7));
        return it;
    endfunction

    task automatic drive(input bit v, input item_t it);
        in_valid   = v;
        in_payload = it.p;
        in_op0     = it.o0;
        in_op0_reg = it.r0;
        in_op1     = it.o1;
        in_op1_reg = it.r1;
    endtask

    // One clock: check stage-side outputs against the model, advance the model, return at posedge+1.
    task automatic step();
        item_t cur;
        bit    iss, rdy;
        @(negedge clk);
        cur = '{in_payload, in_op0, in_op0_reg, in_op1, in_op1_reg};
        iss = mh_valid && !seg_stall && (sb.size() < 2) && !flush;
        rdy = !flush && (!mh_valid || iss);
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("issue_pulse", 64'(st_next_stage_ready), 64'(iss));
        chk("st_op0", 64'(st_op0), mh_valid ? 64'(mh.o0) : 64'd0);
        chk("st_op1", 64'(st_op1), mh_valid ? 64'(mh.o1) : 64'd0);
        if (mh_valid) begin
            chk("st_op0_reg", 64'(st_op0_reg), 64'(mh.r0));
            chk("st_op1_reg", 64'(st_op1_reg), 64'(mh.r1));
        end
`ifdef REG_ACCESS_STALL_PERF_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
        if (mh_valid && seg_stall && !flush && exp_stall != 64'hFFFF_FFFF)
            exp_stall++;
`else
        chk("stall_cycles", 64'(stall_cycles), 64'd0);
`endif
        sb_pre = sb.size();
        if (iss)
            sb.push_back(mh);
        last_acc = in_valid && rdy;
        if (flush)
            mh_valid = 1'b0;
        else if (last_acc) begin
            mh       = cur;
            mh_valid = 1'b1;
        end else if (iss)
            mh_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the buffer head on every handshake, independent of stimulus.
    always @(negedge clk) begin
        item_t e;
        #1;
        if (!reset) begin
            chk("out_valid", 64'(out_valid), 64'(sb_pre != 0));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_payload", out_payload, e.p);
                    chk("out_ops", 64'({out_op0, out_op0_reg, out_op1, out_op1_reg}),
                        64'({e.o0, e.r0, e.o1, e.r1}));
                end
            end
            if (flush)
                sb.delete();
        end
    end

    task automatic push_until_accepted(input item_t it, input int release_at);
        drive(1'b1, it);
        for (int k = 0; k < 12; k++) begin
            if (k == release_at)
                out_ready = 1'b1;
            step();
            if (last_acc)
                break;
        end
        if (!last_acc)
            chk("accept_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        item_t it;
        item_t z = '0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_payload", out_payload, 64'd0);
        chk("rst_st_ops", 64'({st_op0, st_op0_reg, st_op1, st_op1_reg}), 64'd0);
        chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        reset = 1'b0;

        // Single instruction, no hazard
        out_ready = 1'b1;
        it = '0;
        it.p = 64'hA5;
        drive(1'b1, it);
        step();
        drive(1'b0, z);
        repeat (4) step();

        // Hazard hold: segment op1 reg 3, table stalls for 5 cycles
        it = rnd_item();
        it.o1 = 3'b010;
        it.r1 = 3'd3;
        seg_stall = 1'b1;
        drive(1'b1, it);
        step();
        drive(1'b1, rnd_item());
        repeat (5) step();
        seg_stall = 1'b0;
        step();
        drive(1'b0, z);
        repeat (3) step();
`ifdef REG_ACCESS_STALL_PERF_EN
        chk("hazard_stall_count", 64'(stall_cycles), 64'd5);
`endif

        // Backpressure: 4 instructions against a blocked consumer, released on the 4th
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_until_accepted(rnd_item(), 3);
        drive(1'b0, z);
        repeat (6) step();

        // Empty slot masking
        for (int i = 0; i < 4; i++) begin
            seg_stall = 1'($urandom_range(0, 1));
            drive(1'b0, rnd_item());
            step();
        end
        seg_stall = 1'b0;

        // Flush with H full and buffer full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push_until_accepted(rnd_item(), 99);
        drive(1'b1, rnd_item());
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, z);
        repeat (2) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, rnd_item());
            seg_stall = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush = 1'b0;
        seg_stall = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, z);
        repeat (4) step();

        // Async reset while stalled
        out_ready = 1'b0;
        seg_stall = 1'b1;
        it = rnd_item();
        it.o1 = 3'b010;
        drive(1'b1, it);
        step();
        drive(1'b0, z);
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_payload", out_payload, 64'd0);
        chk("mid_rst_st_ops", 64'({st_op0, st_op0_reg, st_op1, st_op1_reg}), 64'd0);
        chk("mid_rst_issue", 64'(st_next_stage_ready), 64'd0);
        chk("mid_rst_stall_cycles", 64'(stall_cycles), 64'd0);
        mh_valid  = 1'b0;
        sb.delete();
        sb_pre    = 0;
        exp_stall = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        seg_stall = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, rnd_item());
        step();
        drive(1'b0, z);
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
